// File: rtl/aes_pkg.sv
// Shared definitions for the iterative AES-128 round controller.
package aes_pkg;

   localparam int unsigned AES128_NR = 10;
   localparam int unsigned ROUND_W   = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      DONE  = 2'd3
   } aes_state_e;

endpackage

// File: rtl/aes_round_ctrl_if.sv
// Handshake and datapath-control bundle between the round controller and its environment.
interface aes_round_ctrl_if;
   import aes_pkg::*;

   logic               in_valid;
   logic               in_ready;
   logic               dp_load;
   logic               dp_issue;
   logic [ROUND_W-1:0] dp_round;
   logic               dp_last;
   logic               dp_capture;
   logic               out_valid;
   logic               out_ready;
   logic               busy;

   // Environment side: supplies blocks and consumes ciphertext.
   modport master (
      output in_valid, out_ready,
      input  in_ready, dp_load, dp_issue, dp_round, dp_last, dp_capture,
             out_valid, busy
   );

   // Controller side.
   modport slave (
      input  in_valid, out_ready,
      output in_ready, dp_load, dp_issue, dp_round, dp_last, dp_capture,
             out_valid, busy
   );

endinterface

// File: rtl/aes_round_timer.sv
// Loadable down-counter that paces each round against the datapath latency.
module aes_round_timer #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load,
   input  logic [W-1:0] load_val,
   input  logic         en,
   output logic         zero
);

   logic [W-1:0] cnt;

   // Counter register: load wins over decrement; never underflows.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= load_val;
      end else if (en && (cnt != '0)) begin
         cnt <= cnt - 1'b1;
      end
   end

   assign zero = (cnt == '0);

endmodule

// File: rtl/aes_round_ctrl.sv
// Sequencer for the iterative AES-128 encryption core: control only, no data path.
module aes_round_ctrl
   import aes_pkg::*;
#(
   parameter int unsigned NR        = AES128_NR,
   parameter int unsigned ROUND_LAT = 3
) (
   input  logic          clk,
   input  logic          rst,
   aes_round_ctrl_if.slave bus
);

   localparam logic [ROUND_W-1:0] NR_V   = ROUND_W'(NR);
   localparam logic [ROUND_W-1:0] LAT_M1 = ROUND_W'(ROUND_LAT - 1);

   aes_state_e         state, state_n;
   logic [ROUND_W-1:0] round, round_n;

   logic               timer_load;
   logic               timer_en;
   logic               timer_zero;

   logic               in_ready_c;
   logic               dp_load_c;
   logic               dp_issue_c;
   logic [ROUND_W-1:0] dp_round_c;
   logic               dp_last_c;
   logic               dp_capture_c;
   logic               out_valid_c;
   logic               busy_c;

   aes_round_timer #(
      .W (ROUND_W)
   ) u_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (timer_load),
      .load_val (LAT_M1),
      .en       (timer_en),
      .zero     (timer_zero)
   );

   // State and round-index registers; reset discards any block in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         round <= '0;
      end else begin
         state <= state_n;
         round <= round_n;
      end
   end

   // Next-state, round update and output decode.
   always_comb begin
      state_n      = state;
      round_n      = round;
      timer_load   = 1'b0;
      timer_en     = 1'b0;
      in_ready_c   = 1'b0;
      dp_load_c    = 1'b0;
      dp_issue_c   = 1'b0;
      dp_round_c   = '0;
      dp_last_c    = 1'b0;
      dp_capture_c = 1'b0;
      out_valid_c  = 1'b0;
      busy_c       = 1'b0;

      case (state)
         IDLE: begin
            in_ready_c = 1'b1;
            if (bus.in_valid) begin
               dp_load_c = 1'b1;
               round_n   = ROUND_W'(1);
               state_n   = ISSUE;
            end
         end

         ISSUE: begin
            busy_c     = 1'b1;
            dp_issue_c = 1'b1;
            dp_round_c = round;
            dp_last_c  = (round == NR_V);
            timer_load = 1'b1;
            state_n    = WAIT;
         end

         WAIT: begin
            busy_c     = 1'b1;
            dp_round_c = round;
            dp_last_c  = (round == NR_V);
            if (timer_zero) begin
               dp_capture_c = 1'b1;
               if (round == NR_V) begin
                  state_n = DONE;
               end else begin
                  round_n = round + 1'b1;
                  state_n = ISSUE;
               end
            end else begin
               timer_en = 1'b1;
            end
         end

         DONE: begin
            busy_c      = 1'b1;
            out_valid_c = 1'b1;
            dp_round_c  = round;
            if (bus.out_ready) begin
               state_n = IDLE;
            end
         end

         default: begin
            state_n = IDLE;
         end
      endcase
   end

   assign bus.in_ready   = in_ready_c;
   assign bus.dp_load    = dp_load_c;
   assign bus.dp_issue   = dp_issue_c;
   assign bus.dp_round   = dp_round_c;
   assign bus.dp_last    = dp_last_c;
   assign bus.dp_capture = dp_capture_c;
   assign bus.out_valid  = out_valid_c;
   assign bus.busy       = busy_c;

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Self-checking bench for aes_round_ctrl at ROUND_LAT=3 and ROUND_LAT=1.
module tb_aes_round_ctrl;

   localparam int NR = 10;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   aes_round_ctrl_if b3 ();
   aes_round_ctrl_if b1 ();

   aes_round_ctrl #(.NR(NR), .ROUND_LAT(3)) u3 (
      .clk (clk),
      .rst (rst),
      .bus (b3.slave)
   );

   aes_round_ctrl #(.NR(NR), .ROUND_LAT(1)) u1 (
      .clk (clk),
      .rst (rst),
      .bus (b1.slave)
   );

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: block age in cycles since acceptance.
   int lat [2] = '{3, 1};
   bit m_act [2];
   int m_k [2];
   int acc_cyc [2];
   bit acc_ok [2];
   bit prev_ov [2];
   int loads0 [$];
   int loads1 [$];

   task automatic chk(input string tag, input int unsigned obs, input int unsigned exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic check_dut(input int d, input logic iv,
                            input logic ir, input logic ld, input logic is,
                            input logic [3:0] rnd, input logic last, input logic cap,
                            input logic ov, input logic bsy);
      int    L, D, kk, ph;
      int    e_ir, e_ld, e_is, e_last, e_cap, e_ov, e_busy, e_rnd;
      string p;
      p = (d == 0) ? "lat3" : "lat1";
      L = lat[d];
      D = NR * (L + 1) + 1;
      e_ir = 0; e_ld = 0; e_is = 0; e_last = 0; e_cap = 0; e_ov = 0; e_busy = 0; e_rnd = 0;
      if (!m_act[d]) begin
         e_ir = 1;
         e_ld = int'(iv);
      end else if (m_k[d] < D) begin
         kk     = m_k[d] - 1;
         e_rnd  = kk / (L + 1) + 1;
         ph     = kk % (L + 1);
         e_is   = (ph == 0) ? 1 : 0;
         e_cap  = (ph == L) ? 1 : 0;
         e_last = (e_rnd == NR) ? 1 : 0;
         e_busy = 1;
      end else begin
         e_ov   = 1;
         e_busy = 1;
         e_rnd  = NR;
      end
      chk({p, ".in_ready"},   32'(ir),   e_ir);
      chk({p, ".dp_load"},    32'(ld),   e_ld);
      chk({p, ".dp_issue"},   32'(is),   e_is);
      chk({p, ".dp_round"},   32'(rnd),  e_rnd);
      chk({p, ".dp_last"},    32'(last), e_last);
      chk({p, ".dp_capture"}, 32'(cap),  e_cap);
      chk({p, ".out_valid"},  32'(ov),   e_ov);
      chk({p, ".busy"},       32'(bsy),  e_busy);
      chk({p, ".excl"}, (32'(ld) + 32'(is) + 32'(cap)) <= 1 ? 1 : 0, 1);
      if (ov && !prev_ov[d] && acc_ok[d])
         chk({p, ".ov_latency"}, cyc - acc_cyc[d], D);
      prev_ov[d] = ov;
      if (ld) begin
         acc_cyc[d] = cyc;
         acc_ok[d]  = 1'b1;
         if (d == 0) loads0.push_back(cyc);
         else        loads1.push_back(cyc);
      end
   endtask

   task automatic model_update(input int d, input logic r, input logic iv, input logic ordy);
      int D;
      D = NR * (lat[d] + 1) + 1;
      if (r) begin
         m_act[d] = 1'b0;
         acc_ok[d] = 1'b0;
      end else if (!m_act[d]) begin
         if (iv) begin
            m_act[d] = 1'b1;
            m_k[d]   = 1;
         end
      end else if (m_k[d] < D) begin
         m_k[d]++;
      end else if (ordy) begin
         m_act[d] = 1'b0;
      end
   endtask

   // One clock cycle: drive, sample at negedge, advance model.
   task automatic step(input logic r, input logic iv0, input logic or0,
                       input logic iv1, input logic or1);
      rst          = r;
      b3.in_valid  = iv0;
      b3.out_ready = or0;
      b1.in_valid  = iv1;
      b1.out_ready = or1;
      @(negedge clk);
      check_dut(0, iv0, b3.in_ready, b3.dp_load, b3.dp_issue, b3.dp_round,
                b3.dp_last, b3.dp_capture, b3.out_valid, b3.busy);
      check_dut(1, iv1, b1.in_ready, b1.dp_load, b1.dp_issue, b1.dp_round,
                b1.dp_last, b1.dp_capture, b1.out_valid, b1.busy);
      model_update(0, r, iv0, or0);
      model_update(1, r, iv1, or1);
      cyc++;
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic ordy0, ordy1, r, iv0, iv1;
      int   bp0, bp1;

      rst          = 1'b1;
      b3.in_valid  = 1'b0;
      b3.out_ready = 1'b1;
      b1.in_valid  = 1'b0;
      b1.out_ready = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      for (int d = 0; d < 2; d++) begin
         m_act[d] = 1'b0; m_k[d] = 0; acc_ok[d] = 1'b0; prev_ov[d] = 1'b0;
      end

      // Reset state while still in reset, then a single block each.
      step(1, 0, 1, 0, 1);
      step(0, 1, 1, 1, 1);
      repeat (50) step(0, 0, 1, 0, 1);

      // Backpressure: hold out_ready low for 10 cycles of out_valid, in_valid high meanwhile.
      step(0, 1, 0, 1, 0);
      bp0 = 0;
      bp1 = 0;
      repeat (80) begin
         ordy0 = (bp0 >= 10);
         ordy1 = (bp1 >= 10);
         if (b3.out_valid) bp0++;
         if (b1.out_valid) bp1++;
         step(0, !ordy0, ordy0, !ordy1, ordy1);
      end
      repeat (5) step(0, 0, 1, 0, 1);

      // Reset mid-operation at cycle 18 of a block, then a fresh block.
      step(0, 1, 1, 1, 1);
      repeat (17) step(0, 0, 1, 0, 1);
      step(1, 0, 1, 0, 1);
      step(0, 0, 1, 0, 1);
      step(0, 1, 1, 1, 1);
      repeat (50) step(0, 0, 1, 0, 1);

      // Back-to-back blocks with in_valid held high.
      loads0.delete();
      loads1.delete();
      repeat (100) step(0, 1, 1, 1, 1);
      chk("lat3.b2b_count", (loads0.size() >= 2) ? 1 : 0, 1);
      chk("lat1.b2b_count", (loads1.size() >= 2) ? 1 : 0, 1);
      if (loads0.size() >= 2) chk("lat3.b2b_period", loads0[1] - loads0[0], NR * 4 + 2);
      if (loads1.size() >= 2) chk("lat1.b2b_period", loads1[1] - loads1[0], NR * 2 + 2);
      repeat (50) step(0, 0, 1, 0, 1);

      // Randomized traffic with occasional reset.
      repeat (2000) begin
         r     = ($urandom_range(0, 99) == 0);
         iv0   = !r && ($urandom_range(0, 2) == 0);
         iv1   = !r && ($urandom_range(0, 2) == 0);
         ordy0 = ($urandom_range(0, 9) < 7);
         ordy1 = ($urandom_range(0, 9) < 7);
         step(r, iv0, ordy0, iv1, ordy1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
